// File: rtl/pixel_fill_writer.sv
// Clipped rectangle fill engine driving port 0 of the 1-bit pixel RAM.
// Build option PIXEL_XOR_EN adds a cmd_xor read-modify-write (invert) fill mode.
module pixel_fill_writer #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_x,
    input  logic [8:0]        cmd_y,
    input  logic [9:0]        cmd_w,
    input  logic [8:0]        cmd_h,
    input  logic              cmd_color,
`ifdef PIXEL_XOR_EN
    input  logic              cmd_xor,
`endif
    output logic              pix_wEn,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              pix_dataIn,
    input  logic              pix_dataOut,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLIP = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_r, next_state_s;
    logic [9:0]        x_r, w_r, cx_r;
    logic [8:0]        y_r, h_r, cy_r;
    logic              color_r;
    logic [10:0]       x_end_r, x_sum_s, x_end_s;
    logic [9:0]        y_end_r, y_sum_s, y_end_s;
    logic [ADDR_W-1:0] row_base_r, addr_r;
    logic              wen_r, data_r, done_r, ready_r, busy_r;
    logic              degenerate_s, last_col_s, last_row_s, pix_step_s;

`ifdef PIXEL_XOR_EN
    logic              xor_r, phase_r;

    // XOR pixels take a read phase (phase_r=0) then a write phase (phase_r=1)
    assign pix_step_s = (state_r == FILL) && (!xor_r || phase_r);
    assign pix_dataIn = (xor_r && wen_r) ? ~pix_dataOut : data_r;
`else
    logic              unused_s;

    assign pix_step_s = (state_r == FILL);
    assign pix_dataIn = data_r;
    assign unused_s   = pix_dataOut;
`endif

    assign pix_wEn   = wen_r;
    assign pix_addr  = addr_r;
    assign done      = done_r;
    assign cmd_ready = ready_r;
    assign busy      = busy_r;

    // Clip bounds from the captured command and the end-of-row/end-of-rect tests
    always_comb begin
        x_sum_s = {1'b0, x_r} + {1'b0, w_r};
        y_sum_s = {1'b0, y_r} + {1'b0, h_r};
        if (x_sum_s > 11'(H_RES)) begin
            x_end_s = 11'(H_RES);
        end else begin
            x_end_s = x_sum_s;
        end
        if (y_sum_s > 10'(V_RES)) begin
            y_end_s = 10'(V_RES);
        end else begin
            y_end_s = y_sum_s;
        end
        degenerate_s = (w_r == 10'd0) || (h_r == 9'd0) ||
                       ({1'b0, x_r} >= 11'(H_RES)) || ({1'b0, y_r} >= 10'(V_RES));
        last_col_s   = (({1'b0, cx_r} + 11'd1) >= x_end_r);
        last_row_s   = (({1'b0, cy_r} + 10'd1) == y_end_r);
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    next_state_s = CLIP;
                end else begin
                    next_state_s = IDLE;
                end
            end
            CLIP: begin
                if (degenerate_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = FILL;
                end
            end
            FILL: begin
                if (pix_step_s && last_col_s && last_row_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = FILL;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Command capture, pixel walk and registered RAM-port outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_r        <= 10'd0;
            y_r        <= 9'd0;
            w_r        <= 10'd0;
            h_r        <= 9'd0;
            color_r    <= 1'b0;
            cx_r       <= 10'd0;
            cy_r       <= 9'd0;
            x_end_r    <= 11'd0;
            y_end_r    <= 10'd0;
            row_base_r <= '0;
            addr_r     <= '0;
            wen_r      <= 1'b0;
            data_r     <= 1'b0;
            done_r     <= 1'b0;
            ready_r    <= 1'b1;
            busy_r     <= 1'b0;
`ifdef PIXEL_XOR_EN
            xor_r      <= 1'b0;
            phase_r    <= 1'b0;
`endif
        end else begin
            wen_r   <= pix_step_s;
            done_r  <= (state_r == DONE);
            ready_r <= (next_state_s == IDLE);
            busy_r  <= (next_state_s != IDLE);
            case (state_r)
                IDLE: begin
                    if (cmd_valid) begin
                        x_r     <= cmd_x;
                        y_r     <= cmd_y;
                        w_r     <= cmd_w;
                        h_r     <= cmd_h;
                        color_r <= cmd_color;
`ifdef PIXEL_XOR_EN
                        xor_r   <= cmd_xor;
`endif
                    end
                end
                CLIP: begin
                    x_end_r    <= x_end_s;
                    y_end_r    <= y_end_s;
                    row_base_r <= ADDR_W'(y_r) * ADDR_W'(H_RES);
                    cx_r       <= x_r;
                    cy_r       <= y_r;
`ifdef PIXEL_XOR_EN
                    phase_r    <= 1'b0;
`endif
                end
                FILL: begin
                    addr_r <= row_base_r + ADDR_W'(cx_r);
                    data_r <= color_r;
`ifdef PIXEL_XOR_EN
                    phase_r <= xor_r && !phase_r;
`endif
                    if (pix_step_s) begin
                        if (!last_col_s) begin
                            cx_r <= cx_r + 10'd1;
                        end else begin
                            cx_r       <= x_r;
                            cy_r       <= cy_r + 9'd1;
                            row_base_r <= row_base_r + ADDR_W'(H_RES);
                        end
                    end
                end
                default: begin
                    cx_r <= cx_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_fill_writer.sv
// Scoreboard bench for pixel_fill_writer: expected writes are queued per command
// and popped as the DUT asserts pix_wEn; a small RAM model feeds pix_dataOut.
module tb_pixel_fill_writer;

    bit          clk = 1'b0;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_x;
    logic [8:0]  cmd_y;
    logic [9:0]  cmd_w;
    logic [8:0]  cmd_h;
    logic        cmd_color;
    logic        xor_in;
    logic        pix_wEn;
    logic [18:0] pix_addr;
    logic        pix_dataIn;
    bit          pix_dataOut;
    logic        busy;
    logic        done;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          acc_cyc  = 0;
    int          first_wr = -1;
    int          wr_count = 0;
    logic [19:0] exp_q[$];
    bit          shadow[int];
    bit          ram [0:524287];

    always #5 clk = ~clk;

    pixel_fill_writer dut (
        .clk        (clk),
        .resetn     (resetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_w      (cmd_w),
        .cmd_h      (cmd_h),
        .cmd_color  (cmd_color),
`ifdef PIXEL_XOR_EN
        .cmd_xor    (xor_in),
`endif
        .pix_wEn    (pix_wEn),
        .pix_addr   (pix_addr),
        .pix_dataIn (pix_dataIn),
        .pix_dataOut(pix_dataOut),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Synchronous-read pixel RAM model on port 0
    always @(posedge clk) begin
        pix_dataOut <= ram[pix_addr];
        if (pix_wEn) ram[pix_addr] <= pix_dataIn;
    end

    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) acc_cyc <= cyc + 1;
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (resetn && pix_wEn) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(pix_addr), 32'hFFFF_FFFF);
            end else begin
                check("wr_addr", 32'(pix_addr), 32'(exp_q[0][18:0]));
                check("wr_data", 32'(pix_dataIn), 32'(exp_q[0][19]));
                void'(exp_q.pop_front());
            end
            check("wr_in_range", 32'(pix_addr < 19'd307200), 32'd1);
            if (first_wr < acc_cyc) first_wr <= cyc;
            wr_count <= wr_count + 1;
        end
    end

    task automatic expect_rect(input int x, y, w, h, input bit c, xr, output int n);
        n = 0;
        for (int yy = y; yy < y + h && yy < 480; yy++) begin
            for (int xx = x; xx < x + w && xx < 640; xx++) begin
                int a;
                bit v;
                a = yy * 640 + xx;
                v = xr ? !(shadow.exists(a) ? shadow[a] : 1'b0) : c;
                shadow[a] = v;
                exp_q.push_back({v, 19'(a)});
                n++;
            end
        end
    endtask

    task automatic send(input int x, y, w, h, input bit c, xr, output int acc);
        cmd_x = 10'(x); cmd_y = 9'(y); cmd_w = 10'(w); cmd_h = 9'(h);
        cmd_color = c; xor_in = xr; cmd_valid = 1'b1;
        for (int i = 0; i < 1000 && !cmd_ready; i++) @(negedge clk);
        if (!cmd_ready) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        acc = acc_cyc;
    endtask

    task automatic wait_done(output int dcyc);
        dcyc = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done) begin
                dcyc = cyc;
                break;
            end
        end
        if (dcyc < 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic fill_test(input string tag, input int x, y, w, h, input bit c, xr);
        int n, n0, acc, dcyc, ppc;
        @(negedge clk);
        n0 = wr_count;
        expect_rect(x, y, w, h, c, xr, n);
        send(x, y, w, h, c, xr, acc);
        wait_done(dcyc);
        @(posedge clk);
        #1;
        ppc = xr ? 2 : 1;
        check({tag, "_writes"}, 32'(wr_count - n0), 32'(n));
        check({tag, "_done_lat"}, 32'(dcyc - acc), 32'(2 + n * ppc));
        if (n > 0) check({tag, "_first_lat"}, 32'(first_wr - acc), 32'(1 + ppc));
        check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n, n0, acc, acc2, dcyc, dcyc2, k;
        resetn = 1'b0; cmd_valid = 1'b0; cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0;
        cmd_color = 1'b0; xor_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wen", 32'(pix_wEn), 32'd0);
        check("rst_addr", 32'(pix_addr), 32'd0);
        check("rst_data", 32'(pix_dataIn), 32'd0);
        resetn = 1'b1;

        fill_test("basic", 10, 2, 3, 2, 1'b1, 1'b0);
        fill_test("clip_corner", 638, 479, 5, 5, 1'b1, 1'b0);
        fill_test("clip_bottom", 100, 478, 2, 10, 1'b0, 1'b0);
        fill_test("degen_w0", 5, 5, 0, 7, 1'b1, 1'b0);
        fill_test("degen_x700", 700, 0, 4, 4, 1'b1, 1'b0);

        // A command offered mid-fill is dropped; the next one lands right after done
        @(negedge clk);
        n0 = wr_count;
        expect_rect(20, 10, 4, 1, 1'b1, 1'b0, n);
        send(20, 10, 4, 1, 1'b1, 1'b0, acc);
        @(negedge clk);
        @(negedge clk);
        cmd_x = 10'd0; cmd_y = 9'd0; cmd_w = 10'd1; cmd_h = 9'd1; cmd_valid = 1'b1;
        check("busy_ready_low", 32'(cmd_ready), 32'd0);
        check("busy_high", 32'(busy), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_done(dcyc);
        check("b2b_ready", 32'(cmd_ready), 32'd1);
        check("busy_writes", 32'(wr_count - n0), 32'(n));
        expect_rect(30, 11, 2, 1, 1'b0, 1'b0, n);
        send(30, 11, 2, 1, 1'b0, 1'b0, acc2);
        check("b2b_accept", 32'(acc2 - dcyc), 32'd1);
        wait_done(dcyc2);
        @(posedge clk);
        #1;
        check("b2b_first_lat", 32'(first_wr - acc2), 32'd2);
        check("b2b_done_lat", 32'(dcyc2 - acc2), 32'd4);
        check("b2b_sb_empty", 32'(exp_q.size()), 32'd0);

`ifdef PIXEL_XOR_EN
        fill_test("xor_pre1", 1, 1, 1, 1, 1'b1, 1'b0);
        fill_test("xor_pre0", 2, 1, 1, 1, 1'b0, 1'b0);
        fill_test("xor_fill", 1, 1, 2, 1, 1'b0, 1'b1);
        check("xor_ram641", 32'(ram[641]), 32'd0);
        check("xor_ram642", 32'(ram[642]), 32'd1);
`endif

        // Reset mid-fill on the 10th write
        @(negedge clk);
        expect_rect(0, 0, 100, 1, 1'b1, 1'b0, n);
        send(0, 0, 100, 1, 1'b1, 1'b0, acc);
        k = 0;
        for (int i = 0; i < 300 && k < 10; i++) begin
            @(negedge clk);
            if (pix_wEn) k++;
        end
        check("midfill_reach", 32'(k), 32'd10);
        resetn = 1'b0;
        #1;
        check("midrst_wen", 32'(pix_wEn), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        n0 = wr_count;
        repeat (20) @(negedge clk);
        @(posedge clk);
        #1;
        check("midrst_no_writes", 32'(wr_count - n0), 32'd0);
        check("midrst_ready", 32'(cmd_ready), 32'd1);
        check("midrst_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
